// File: rtl/gpp_pkg.sv
// ----------------------------------------------------------------------------
// gpp_pkg -- shared definitions for the instruction fetch path.
//   * Instruction word field positions ([15:10] opcode, [9] register select,
//     [8:0] value/address).
//   * Opcode range constants: HALT = 0, LS = 1..2, BR = 3..9, ALU = 10..63.
//   * Fetch FSM state enum and an opcode classifier used by the fetch FSM.
// ----------------------------------------------------------------------------
package gpp_pkg;

  // Instruction word fields
  localparam int OPC_MSB    = 15;
  localparam int OPC_LSB    = 10;
  localparam int OPC_W      = OPC_MSB - OPC_LSB + 1;
  localparam int REGSEL_BIT = 9;
  localparam int VAL_MSB    = 8;
  localparam int VAL_LSB    = 0;

  // Opcode ranges
  localparam logic [OPC_W-1:0] OPC_HALT    = 6'd0;
  localparam logic [OPC_W-1:0] OPC_LS_MIN  = 6'd1;
  localparam logic [OPC_W-1:0] OPC_LS_MAX  = 6'd2;
  localparam logic [OPC_W-1:0] OPC_BR_MIN  = 6'd3;
  localparam logic [OPC_W-1:0] OPC_BR_MAX  = 6'd9;
  localparam logic [OPC_W-1:0] OPC_ALU_MIN = 6'd10;

  // Fetch FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_BRWAIT  = 3'd4,
    ST_HALT    = 3'd5
  } fetch_state_t;

  // Opcode classes as seen by the fetch unit
  typedef enum logic [1:0] {
    OPK_HALT = 2'd0,
    OPK_LS   = 2'd1,
    OPK_BR   = 2'd2,
    OPK_ALU  = 2'd3
  } opc_kind_t;

  function automatic opc_kind_t opc_kind(input logic [OPC_W-1:0] opc);
    if (opc == OPC_HALT)
      return OPK_HALT;
    else if (opc >= OPC_BR_MIN && opc <= OPC_BR_MAX)
      return OPK_BR;
    else if (opc >= OPC_ALU_MIN)
      return OPK_ALU;
    else
      return OPK_LS;
  endfunction

endpackage

// File: rtl/ifetch_pc.sv
// ----------------------------------------------------------------------------
// ifetch_pc -- program counter register for the fetch unit.
//   Load has priority over increment; increment wraps modulo 2^ADDR_W.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low (clears PC to 0)
//   i_load     in   load i_load_val into the PC
//   i_load_val in   value to load
//   i_inc      in   advance PC by one (wrapping)
//   o_pc       out  current PC
// ----------------------------------------------------------------------------
module ifetch_pc #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_pc <= '0;
    else if (i_load)
      r_pc <= i_load_val;
    else if (i_inc)
      r_pc <= r_pc + ADDR_W'(1);  // natural overflow gives the wrap
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch unit.
//   Fetches one word per instruction from a program memory with one cycle
//   read latency, presents it to the decoder (read_line/line_data/pc), and
//   follows halt / branch resolution.  Non-branch throughput is one
//   instruction every 3 cycles (REQ -> WAIT -> PRESENT).
//
// Optional feature: define IFETCH_COUNT_EN to build the saturating issued-
//   instruction counter on instr_count; otherwise instr_count is tied to 0.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   start         in   begin fetching at address 0 (accepted in IDLE/HALT)
//   stall         in   hold the presented instruction
//   branch_valid  in   branch outcome resolved (used only in BRWAIT)
//   branch_taken  in   1: jump to branch_addr, 0: fall through to pc+1
//   branch_addr   in   branch target
//   mem_rd_en     out  program memory read strobe (REQ only)
//   mem_addr      out  program memory read address
//   mem_data      in   read data, valid the cycle after the strobe
//   read_line     out  line_data valid to the decoder
//   line_data     out  fetched instruction word
//   pc            out  address of the word in line_data
//   halted        out  fetch stopped on a HALT opcode
//   instr_count   out  issued-instruction count (see IFETCH_COUNT_EN)
// ----------------------------------------------------------------------------
module ifetch
  import gpp_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              read_line,
  output logic [DATA_W-1:0] line_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       instr_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [DATA_W-1:0] r_line;
  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_inc;
  opc_kind_t         w_kind;

  assign w_kind = opc_kind(r_line[OPC_MSB:OPC_LSB]);

  // --------------------------------------------------------------------------
  // Next-state and PC control
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = '0;
    w_pc_inc      = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_pc_load = 1'b1;  // restart always at address 0
          w_next    = ST_REQ;
        end
      end
      ST_REQ:  w_next = ST_WAIT;
      ST_WAIT: w_next = ST_PRESENT;
      ST_PRESENT: begin
        if (!stall) begin
          case (w_kind)
            OPK_HALT: w_next = ST_HALT;
            OPK_BR:   w_next = ST_BRWAIT;
            default: begin
              w_pc_inc = 1'b1;
              w_next   = ST_REQ;
            end
          endcase
        end
      end
      ST_BRWAIT: begin
        if (branch_valid) begin
          if (branch_taken) begin
            w_pc_load     = 1'b1;
            w_pc_load_val = branch_addr;
          end else begin
            w_pc_inc = 1'b1;
          end
          w_next = ST_REQ;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Capture the word returned for the strobe issued in REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_line <= '0;
    else if (r_state == ST_WAIT)
      r_line <= mem_data;
  end

  ifetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_load_val),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_rd_en = (r_state == ST_REQ);
  assign mem_addr  = w_pc;
  assign read_line = (r_state == ST_PRESENT) && !stall;
  assign line_data = r_line;
  assign pc        = w_pc;
  assign halted    = (r_state == ST_HALT);

`ifdef IFETCH_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_start_acc;

  // Only a start that actually restarts the fetch clears the count.
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_instr_count <= '0;
    else if (w_start_acc)
      r_instr_count <= '0;
    else if (read_line && (r_instr_count != 16'hFFFF))
      r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch: directed steps followed by a
// randomized instruction stream checked against an instruction-level model.
// ----------------------------------------------------------------------------
module tb_ifetch;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int MEM_N  = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic              branch_valid;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              read_line;
  logic [DATA_W-1:0] line_data;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [15:0]       instr_count;

  logic [DATA_W-1:0] mem [MEM_N];
  int n_err = 0;
  int n_chk = 0;
  int rd_cnt = 0;

  ifetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .read_line    (read_line),
    .line_data    (line_data),
    .pc           (pc),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  // Program memory: data one cycle after the strobe; also counts strobes.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data <= mem[mem_addr];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_line(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (read_line !== 1'b1 && cyc < 50);
    chk(tag, read_line, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"},    pc, 0);
    chk({tag, "_ld"},    line_data, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_cnt"},   instr_count, 0);
    chk({tag, "_rl"},    read_line, 0);
    chk({tag, "_rden"},  mem_rd_en, 0);
    chk({tag, "_halt"},  halted, 0);
  endtask

  // Expected counter value after n issued instructions.
  function automatic int exp_cnt(input int n);
`ifdef IFETCH_COUNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0 * n;
`endif
  endfunction

  // Instruction-level model: 0 = halt, 1 = sequential, 2 = branch.
  function automatic int ref_kind(input logic [15:0] w);
    int opc;
    opc = int'(w) / 1024;
    if (opc == 0) return 0;
    if (opc >= 3 && opc <= 9) return 2;
    return 1;
  endfunction

  initial begin
    int cyc, rd0, mpc, npres, k, d, tk, tg, sel, opc;

    rst = 1'b0; start = 1'b0; stall = 1'b0;
    branch_valid = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'h2800;

    // Reset state, then no reads until start
    repeat (3) tick();
    chk_zero("reset");
    @(negedge clk) rst = 1'b1;
    rd0 = rd_cnt;
    repeat (5) tick();
    chk("no_rd_before_start", rd_cnt, rd0);

    // Basic program: LS, ALU, HALT
    mem[0] = 16'h0401; mem[1] = 16'h2803; mem[2] = 16'h0000;
    pulse_start();
    chk("req_rden", mem_rd_en, 1);
    chk("req_addr", mem_addr, 0);
    tick();
    chk("wait_rl", read_line, 0);
    chk("wait_rden", mem_rd_en, 0);
    tick();
    chk("first_rl", read_line, 1);
    chk("first_ld", line_data, 16'h0401);
    chk("first_pc", pc, 0);
    wait_line("l1_rl", cyc);
    chk("thru_cyc", cyc, 3);
    chk("l1_ld", line_data, 16'h2803);
    chk("l1_pc", pc, 1);
    wait_line("l2_rl", cyc);
    chk("l2_ld", line_data, 16'h0000);
    chk("l2_pc", pc, 2);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 2);
    chk("halt_rl", read_line, 0);
    chk("halt_cnt", instr_count, exp_cnt(3));
    rd0 = rd_cnt;
    repeat (10) tick();
    chk("no_rd_after_halt", rd_cnt, rd0);
    chk("halt_hold", halted, 1);

    // Stall hold, start ignored while fetching, restart from HALT
    mem[0] = 16'h2801; mem[1] = 16'h2802; mem[2] = 16'h0000;
    pulse_start();
    wait_line("st0_rl", cyc);
    chk("st0_cyc", cyc, 2);
    chk("st0_ld", line_data, 16'h2801);
    chk("st0_cnt_clr", instr_count, exp_cnt(0));
    stall = 1'b1;
    #1;
    chk("stall_rl", read_line, 0);
    for (int s = 0; s < 5; s++) begin
      if (s == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk("stall_hold_rl", read_line, 0);
      chk("stall_hold_ld", line_data, 16'h2801);
      chk("stall_hold_pc", pc, 0);
      chk("stall_hold_rden", mem_rd_en, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_rl", read_line, 1);
    wait_line("st1_rl", cyc);
    chk("st1_cyc", cyc, 3);
    chk("st1_pc", pc, 1);
    chk("st1_ld", line_data, 16'h2802);
    wait_line("st2_rl", cyc);
    tick();
    chk("st_halted", halted, 1);
    chk("st_cnt", instr_count, exp_cnt(3));

    // Branch at pc 4, taken then not taken; branch inputs ignored elsewhere
    for (int i = 0; i < 4; i++) mem[i] = 16'h2800 + 16'(i);
    mem[4] = 16'h0C20; mem[5] = 16'h0000; mem[32] = 16'h0000;
    for (int t = 0; t < 2; t++) begin
      pulse_start();
      for (int p = 0; p <= 4; p++) begin
        wait_line("br_seq_rl", cyc);
        chk("br_seq_pc", pc, p);
        if (p == 0) begin
          branch_valid = 1'b1; branch_taken = 1'b1; branch_addr = 9'h1FF;
        end
        if (p == 3) branch_valid = 1'b0;
      end
      chk("br_word", line_data, 16'h0C20);
      tick();
      chk("brwait_rden", mem_rd_en, 0);
      chk("brwait_halted", halted, 0);
      repeat (4) begin
        tick();
        chk("brwait_hold_rden", mem_rd_en, 0);
        chk("brwait_hold_rl", read_line, 0);
      end
      branch_valid = 1'b1; branch_taken = (t == 0); branch_addr = 9'h020;
      tick();
      branch_valid = 1'b0;
      chk("br_next_rden", mem_rd_en, 1);
      chk("br_next_addr", mem_addr, (t == 0) ? 32'h20 : 32'h5);
      wait_line("br_tgt_rl", cyc);
      chk("br_tgt_pc", pc, (t == 0) ? 32'h20 : 32'h5);
      tick();
      chk("br_tgt_halted", halted, 1);
    end

    // PC wrap 511 -> 0, then reset while in BRWAIT
    mem[0] = 16'h0DFF; mem[1] = 16'h0C07; mem[511] = 16'h2800;
    pulse_start();
    wait_line("wr0_rl", cyc);
    chk("wr0_ld", line_data, 16'h0DFF);
    tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_addr = 9'h1FF;
    tick();
    branch_valid = 1'b0;
    chk("wr_jump_addr", mem_addr, 9'h1FF);
    wait_line("wr511_rl", cyc);
    chk("wr511_pc", pc, 9'h1FF);
    tick();
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_rden", mem_rd_en, 1);
    wait_line("wr_again_rl", cyc);
    chk("wr_again_pc", pc, 0);
    tick();
    branch_valid = 1'b1; branch_taken = 1'b0; branch_addr = 9'h1FF;
    tick();
    branch_valid = 1'b0;
    chk("nt_addr", mem_addr, 1);
    wait_line("pc1_rl", cyc);
    chk("pc1_ld", line_data, 16'h0C07);
    tick();
    chk("brwait2_pc", pc, 1);
    #2 rst = 1'b0;
    #1 chk_zero("rst_brwait");
    @(negedge clk) rst = 1'b1;

    // Reset while in WAIT, restart fetches address 0
    mem[0] = 16'h2800;
    pulse_start();
    chk("rs_addr", mem_addr, 0);
    wait_line("rs0_rl", cyc);
    tick();
    tick();
    chk("wait_pc1", pc, 1);
    #2 rst = 1'b0;
    #1 chk_zero("rst_wait");
    @(negedge clk) rst = 1'b1;
    pulse_start();
    chk("post_rst_rden", mem_rd_en, 1);
    chk("post_rst_addr", mem_addr, 0);
    wait_line("post_rst_rl", cyc);
    chk("post_rst_ld", line_data, 16'h2800);

    // Randomized stream (no halts), checked against the instruction model
    for (int i = 0; i < MEM_N; i++) begin
      sel = $urandom_range(0, 2);
      opc = (sel == 0) ? $urandom_range(3, 9) : (sel == 1) ? $urandom_range(1, 2)
                                              : $urandom_range(10, 63);
      mem[i] = 16'(opc * 1024 + $urandom_range(0, 1023));
    end
    rst = 1'b0;
    tick();
    @(negedge clk) rst = 1'b1;
    pulse_start();
    mpc = 0;
    npres = 0;
    for (int n = 0; n < 40; n++) begin
      wait_line("rnd_rl", cyc);
      chk("rnd_pc", pc, mpc);
      chk("rnd_ld", line_data, mem[mpc]);
      npres++;
      k = $urandom_range(0, 2);
      if (k != 0) begin
        stall = 1'b1;
        repeat (k) tick();
        stall = 1'b0;
        #1;
      end
      if (ref_kind(mem[mpc]) == 2) begin
        tick();
        chk("rnd_brwait_rden", mem_rd_en, 0);
        d = $urandom_range(0, 3);
        repeat (d) tick();
        tk = $urandom_range(0, 1);
        tg = $urandom_range(0, MEM_N - 1);
        branch_valid = 1'b1; branch_taken = tk[0]; branch_addr = 9'(tg);
        tick();
        branch_valid = 1'b0;
        mpc = (tk != 0) ? tg : (mpc + 1) % MEM_N;
        chk("rnd_br_addr", mem_addr, mpc);
      end else begin
        mpc = (mpc + 1) % MEM_N;
      end
    end
    tick();
    chk("rnd_cnt", instr_count, exp_cnt(npres));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set program-memory address and PC width.
REQ-002 Parameter DATA_W, default 16, SHALL set instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL begin fetching at address 0 when sampled high in IDLE or HALT.
REQ-006 stall  input  1  SHALL hold the presented instruction while high.
REQ-007 branch_valid  input  1  SHALL mark the branch result as resolved for the pending branch.
REQ-008 branch_taken  input  1  SHALL select branch_addr (1) or PC+1 (0), sampled with branch_valid.
REQ-009 branch_addr  input  ADDR_W  SHALL be the branch target.
REQ-010 mem_rd_en  output  1  SHALL be the program-memory read strobe.
REQ-011 mem_addr  output  ADDR_W  SHALL be the program-memory read address.
REQ-012 mem_data  input  DATA_W  SHALL be the read data, valid one cycle after the strobe.
REQ-013 read_line  output  1  SHALL qualify line_data to the instruction decoder.
REQ-014 line_data  output  DATA_W  SHALL be the fetched instruction: [15:10] opcode, [9] register select, [8:0] value/address.
REQ-015 pc  output  ADDR_W  SHALL be the address of the instruction in line_data.
REQ-016 halted  output  1  SHALL be high in HALT.
REQ-017 instr_count  output  16  SHALL be the issued-instruction count (see Configuration).

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, PRESENT, BRWAIT and HALT.
REQ-019 IDLE: on start, pc SHALL be set to 0 and the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-020 REQ: mem_rd_en=1 and mem_addr=pc SHALL be driven for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-021 WAIT: mem_data SHALL be registered into line_data, then the FSM SHALL go to PRESENT.
REQ-022 PRESENT: read_line SHALL be high when stall=0 and low when stall=1; while stall=1 the FSM SHALL remain in PRESENT with line_data and pc unchanged.
REQ-023 PRESENT, stall=0, opcode 0: the FSM SHALL go to HALT.
REQ-024 PRESENT, stall=0, opcode 1-2 or 10-63: pc SHALL become pc+1 and the FSM SHALL go to REQ.
REQ-025 PRESENT, stall=0, opcode 3-9: the FSM SHALL go to BRWAIT.
REQ-026 BRWAIT: the FSM SHALL wait indefinitely for branch_valid; on branch_valid, pc SHALL become branch_taken ? branch_addr : pc+1 and the FSM SHALL go to REQ.
REQ-027 PC increment SHALL wrap modulo 2^ADDR_W (511+1=0).
REQ-028 Timing: read_line SHALL first rise after the third rising edge that samples start; steady non-branch throughput SHALL be one instruction per 3 cycles.
REQ-029 start SHALL be ignored outside IDLE and HALT.
REQ-030 Branch inputs SHALL be ignored outside BRWAIT.
REQ-031 HALT: halted=1, read_line=0 and mem_rd_en=0 SHALL hold; start SHALL restart the fetch at address 0 via REQ.
REQ-032 mem_rd_en SHALL be 0 in every state except REQ.

Reset
REQ-033 Reset assertion SHALL, at any time including mid-fetch or in BRWAIT, force IDLE with pc, line_data, mem_addr, instr_count, read_line, mem_rd_en and halted all 0.
REQ-034 After reset release, no memory read SHALL occur until start.

Configuration
REQ-035 With IFETCH_COUNT_EN defined, instr_count SHALL increment once per cycle with read_line=1, saturate at 0xFFFF, and clear on reset or on start.
REQ-036 Without IFETCH_COUNT_EN, instr_count SHALL be constant 0 and no counter logic SHALL be present.

Structure
REQ-037 The shared package gpp_pkg SHALL hold the opcode field positions, the opcode range constants (HALT=0, LS 1-2, BR 3-9, ALU 10 and above) and the fetch state enum.
REQ-038 One sub-module, ifetch_pc, SHALL implement the PC register with load, increment and wrap; the FSM SHALL stay in ifetch.

Verification
REQ-039 Memory holds 0x0401, 0x2803, 0x0000; pulse start -> read_line rises for line_data 0x0401 (pc 0), then 0x2803 (pc 1); halted=1 after pc 2; mem_rd_en never rises after halt.
REQ-040 Hold stall=1 for 5 cycles in PRESENT -> read_line=0 and line_data/pc unchanged; next read_line follows stall release.
REQ-041 Word 0x0C20 (opcode 3) at pc 4, branch_valid=1, branch_taken=1, branch_addr 0x020 after 4 cycles -> next mem_addr=0x020; the same case with branch_taken=0 -> next mem_addr=5.
REQ-042 Start at pc 511 with an ALU word -> next mem_addr=0.
REQ-043 Assert rst in WAIT and in BRWAIT -> all outputs 0 immediately; start afterwards fetches address 0.
REQ-044 With IFETCH_COUNT_EN, 3 issued instructions -> instr_count=3; without it, instr_count stays 0.
